// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  // Width of the port-1 starvation counter; holds limits up to 15.
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_starve_counter.sv
// Port-1 starvation counter: clears on grant or idle, counts waiting
// cycles, saturates at the limit and flags the cycle the limit is reached.
module rf_starve_counter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wait_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] inc;

  // Next count and limit flag; the flag fires on the increment that reaches LIMIT.
  always_comb begin
    inc   = cnt_q + CNT_W'(1);
    cnt_d = cnt_q;
    hit_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != LIMIT)) begin
      cnt_d = inc;
      hit_o = (inc == LIMIT);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter for the register file's single write port.
// Port 0 (pipeline) has fixed priority; port 1 (long-latency unit) is
// forced through after STARVE_LIMIT waiting cycles. The winning write is
// registered one cycle ahead of the register-file write.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          p0_valid,
  output logic                          p0_ready,
  input  logic [rf_pkg::REG_ADDR_W-1:0] p0_rd,
  input  logic [XLEN-1:0]               p0_data,
  input  logic                          p1_valid,
  output logic                          p1_ready,
  input  logic [rf_pkg::REG_ADDR_W-1:0] p1_rd,
  input  logic [XLEN-1:0]               p1_data,
  output logic                          rf_we,
  output logic [rf_pkg::REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]               rf_wd3,
  output logic [rf_pkg::CNT_W-1:0]      starve_cnt
);

  rf_pkg::arb_state_e state_q;
  rf_pkg::arb_state_e state_d;

  logic                          p1_wait;
  logic                          p1_clear;
  logic                          starve_hit;

  logic                          rf_we_q;
  logic                          rf_we_d;
  logic [rf_pkg::REG_ADDR_W-1:0] rf_a3_q;
  logic [rf_pkg::REG_ADDR_W-1:0] rf_a3_d;
  logic [XLEN-1:0]               rf_wd3_q;
  logic [XLEN-1:0]               rf_wd3_d;

  // Grants: fixed priority in NORMAL, port 1 only in FORCE1, none during reset.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        rf_pkg::FORCE1: p1_ready = p1_valid;
        default: begin
          p0_ready = p0_valid;
          p1_ready = p1_valid && !p0_valid;
        end
      endcase
    end
  end

  assign p1_wait  = p1_valid && !p1_ready;
  assign p1_clear = p1_ready || !p1_valid;

  rf_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .wait_i  (p1_wait),
    .clear_i (p1_clear),
    .cnt_o   (starve_cnt),
    .hit_o   (starve_hit)
  );

  // Next state: FORCE1 lasts exactly one cycle, entered when the wait hits the limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      rf_pkg::FORCE1: state_d = rf_pkg::NORMAL;
      default: if (starve_hit) state_d = rf_pkg::FORCE1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= rf_pkg::NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Select the granted write; x0 writes are accepted but never reach the port.
  always_comb begin
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    if (p0_ready && (p0_rd != '0)) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = p0_rd;
      rf_wd3_d = p0_data;
    end else if (p1_ready && (p1_rd != '0)) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = p1_rd;
      rf_wd3_d = p1_data;
    end
  end

  // Write-port register; reset clears a pending write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

endmodule
